// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and helpers for the boot-time instruction-memory loader.
//   loader_state_e : FSM state encoding (3 bits, IDLE..ERR)
//   HDR_BYTES      : bytes in the big-endian length header
//   WORD_BYTES     : bytes per instruction word
//   lenTooBig()    : header-length range check against the memory depth
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_e;

  // The length check runs at 17 bits so that a full 2^16-word memory is
  // still representable. Once the memory holds 2^16 words or more, no 16-bit
  // length can exceed it, so the check is simply false.
  function automatic logic lenTooBig(input logic [15:0] len, input int addrW);
    logic [16:0] depth;
    if (addrW >= 16) begin
      return 1'b0;
    end
    depth = 17'd1 << addrW;
    return ({1'b0, len} > depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream handshake and the instruction-memory write port.
//   byte_in/byte_valid : stream data and qualifier from the boot source
//   byte_ready         : loader accepts a byte this cycle
//   imem_we            : one-cycle write strobe per word
//   imem_addr          : word address (ADDR_W bits)
//   imem_wdata         : 32-bit word to write
// master = the loader, slave = the environment (byte source + memory).
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 10
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Packs a big-endian byte stream into 32-bit words: the first byte of a word
// ends up in [31:24] after four shifts.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   clear_i      : restart at byte 0 of a fresh word
//   shift_i      : accept byte_i this cycle
//   byte_i       : incoming byte
//   word_o       : current shift-register contents
//   full_o       : this shift completes a word (fourth byte)
// ---------------------------------------------------------------------------
import imem_loader_pkg::*;

module word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [31:0] shreg_q;
  logic [1:0]  cnt_q;

  // Shift register and byte counter. The counter wraps naturally after the
  // fourth byte, so consecutive words need no explicit clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[23:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word_o = shreg_q;
  assign full_o = shift_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Reads a 16-bit big-endian
// length header N, then N big-endian 32-bit words, and writes them to word
// addresses 0..N-1. The CPU is held in reset until the last word commits.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   start        : one-cycle pulse, honoured only in IDLE, DONE or ERR
//   bus          : byte handshake + instruction-memory write port (master)
//   cpu_hold     : 1 keeps the pipeline in reset
//   done         : load finished successfully
//   error        : header length exceeded the memory depth
// ---------------------------------------------------------------------------
import imem_loader_pkg::*;

module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     start,
  imem_loader_if.master bus,
  output logic     cpu_hold,
  output logic     done,
  output logic     error
);

  loader_state_e     state_q, state_d;
  logic [7:0]        lenHi_q, lenHi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   wordCnt_q, wordCnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              byteReady;
  logic              writeEn;
  logic              xfer;
  logic [15:0]       lenIn;
  logic [ADDR_W:0]   wordsAfter;
  logic              lastWord;
  logic              asmClear;
  logic              asmShift;
  logic              asmFull;
  logic [31:0]       asmWord;

  assign xfer       = bus.byte_valid && byteReady;
  assign lenIn      = {lenHi_q, bus.byte_in};
  assign wordsAfter = wordCnt_q + 1'b1;
  // The word counter is ADDR_W+1 bits and never exceeds N, so comparing its
  // 16-bit view against the header length is exact.
  assign lastWord   = (16'(wordsAfter) == len_q);

  assign asmClear   = (state_q == ST_HDR1) && xfer;
  assign asmShift   = (state_q == ST_DATA) && xfer;

  word_assembler u_asm (
    .clock   (clock),
    .reset   (reset),
    .clear_i (asmClear),
    .shift_i (asmShift),
    .byte_i  (bus.byte_in),
    .word_o  (asmWord),
    .full_o  (asmFull)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only looked at in the idle/terminal states,
  // so a load in progress can never be restarted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        if (xfer) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        if (xfer) begin
          if (lenIn == 16'd0) begin
            state_d = ST_DONE;
          end else if (lenTooBig(lenIn, ADDR_W)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asmFull) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = lastWord ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERR: begin
        if (start) state_d = ST_HDR0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    byteReady = 1'b0;
    writeEn   = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      ST_HDR0, ST_HDR1, ST_DATA: byteReady = 1'b1;
      ST_WRITE:                  writeEn   = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ST_ERR:                    error     = 1'b1;
      default: ;
    endcase
  end

  // Header, word-counter and write-port holding registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lenHi_q   <= '0;
      len_q     <= '0;
      wordCnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      lenHi_q   <= lenHi_d;
      len_q     <= len_d;
      wordCnt_q <= wordCnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // The word counter doubles as the write address. addr_q/wdata_q remember
  // the last written word so the write port stays still between strobes.
  always_comb begin
    lenHi_d   = lenHi_q;
    len_d     = len_q;
    wordCnt_d = wordCnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      ST_HDR0: begin
        if (xfer) lenHi_d = bus.byte_in;
      end
      ST_HDR1: begin
        if (xfer) begin
          len_d     = lenIn;
          wordCnt_d = '0;
        end
      end
      ST_WRITE: begin
        addr_d    = wordCnt_q[ADDR_W-1:0];
        wdata_d   = asmWord;
        wordCnt_d = wordsAfter;
      end
      default: ;
    endcase
  end

  assign bus.byte_ready = byteReady;
  assign bus.imem_we    = writeEn;
  assign bus.imem_addr  = writeEn ? wordCnt_q[ADDR_W-1:0] : addr_q;
  assign bus.imem_wdata = writeEn ? asmWord : wdata_q;

endmodule
